uart_tx_queue: RTL

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

---
 rtl/uart_tx_queue.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a UART transmitter: pops the head into a registered tx_byte with a start pulse.
// Optional sticky overflow flag is built only when UART_TX_QUEUE_OVERFLOW_EN is defined.
module uart_tx_queue #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  input  logic                  is_transmitting,
  output logic                  transmit,
  output logic [7:0]            tx_byte,
  output logic                  overflow
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DepthCount = (DEPTH_LOG2 + 1)'(Depth);

  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StWaitStart = 2'd1;
  localparam logic [1:0] StWaitDone  = 2'd2;

  // Last timer value in WAIT_START; timer counts 0..14, i.e. 15 cycles.
  localparam logic [3:0] StartTimeout = 4'd14;

  logic [7:0]            mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic [1:0]            state_q, state_d;
  logic [3:0]            timer_q, timer_d;
  logic                  transmit_q;
  logic [7:0]            tx_byte_q;

  logic                  push;
  logic                  pop;
  logic                  head_valid;
  logic [7:0]            head_data;

  assign full     = (count_q == DepthCount);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign transmit = transmit_q;
  assign tx_byte  = tx_byte_q;

  assign push = wr_en && !full;

  // A byte being pushed into an empty FIFO is forwarded straight to the head so it can
  // start in the very next cycle; pointers still advance together, keeping them aligned.
  assign head_valid = !empty || push;
  assign head_data  = empty ? wr_data : mem_q[rd_ptr_q];
  assign pop        = (state_q == StIdle) && head_valid && !is_transmitting;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      StIdle: begin
        if (pop) begin
          state_d = StWaitStart;
          timer_d = '0;
        end
      end
      StWaitStart: begin
        if (is_transmitting) begin
          state_d = StWaitDone;
        end else if (timer_q == StartTimeout) begin
          // UART never acknowledged; treat the byte as sent.
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (!is_transmitting) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      transmit_q <= 1'b0;
      tx_byte_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      transmit_q <= pop;
      if (pop) begin
        tx_byte_q <= head_data;
      end
    end
  end

`ifdef UART_TX_QUEUE_OVERFLOW_EN
  logic overflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (wr_en && full) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

  a_single_pulse: assert property (@(posedge clk) disable iff (rst) transmit_q |=> !transmit_q);
  a_count_range:  assert property (@(posedge clk) disable iff (rst) count_q <= DepthCount);

endmodule
